// File: rtl/cc_rr_encoder.sv
// cc_rr_encoder
// Serialises a snapshot of active-low register requests (one line per
// register code 2..15) into 4-bit register-select codes, one per
// valid/ready handshake.
//
// Handshake: a code transfers on a rising edge where valid=1 and ready=1.
// valid, selection and pendingcount are held stable while ready=0.
// valid never drops without a transfer, except on reset.
//
// Ports:
//   CC_ENCODER_CLOCK_50            in   system clock, rising edge
//   CC_ENCODER_RESET_InLow         in   asynchronous active-low reset
//   CC_ENCODER_request_InBUS       in   active-low requests, bit k -> code k+2
//   CC_ENCODER_ready_InLow         in   consumer ready (active-high)
//   CC_ENCODER_selection_OutBUS    out  granted code, 0 when idle
//   CC_ENCODER_valid_Out           out  code valid
//   CC_ENCODER_pendingcount_OutBUS out  codes left in batch incl. presented one
//
// Build option: CC_ENCODER_ROUNDROBIN_EN selects round-robin grant order
// with a persistent pointer. Without it, the lowest pending index wins.
module cc_rr_encoder #(
  parameter int DATAWIDTH_ENCODER_REQUEST = 14,
  parameter int DATAWIDTH_ENCODER_OUT     = 4
) (
  input  logic                                 CC_ENCODER_CLOCK_50,
  input  logic                                 CC_ENCODER_RESET_InLow,
  input  logic [DATAWIDTH_ENCODER_REQUEST-1:0] CC_ENCODER_request_InBUS,
  input  logic                                 CC_ENCODER_ready_InLow,
  output logic [DATAWIDTH_ENCODER_OUT-1:0]     CC_ENCODER_selection_OutBUS,
  output logic                                 CC_ENCODER_valid_Out,
  output logic [DATAWIDTH_ENCODER_OUT-1:0]     CC_ENCODER_pendingcount_OutBUS
);

  localparam int REQ   = DATAWIDTH_ENCODER_REQUEST;
  localparam int OUT   = DATAWIDTH_ENCODER_OUT;
  localparam int IDX_W = $clog2(REQ);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [REQ-1:0]     mask_q, mask_d;
  logic [OUT-1:0]     cnt_q, cnt_d;
  logic [OUT-1:0]     sel_q, sel_d;
  logic               valid_q, valid_d;

  logic [REQ-1:0]     req_act;
  logic [IDX_W-1:0]   cur_idx;
  logic [REQ-1:0]     remain;
  logic [IDX_W-1:0]   start_idle;
  logic [IDX_W-1:0]   start_serve;

  // First set bit of mask found scanning upward from start, wrapping at REQ.
  function automatic logic [IDX_W-1:0] pick(input logic [REQ-1:0] mask,
                                            input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] jj;
    logic             found;
    int               j;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ; i++) begin
      j = int'(start) + i;
      if (j >= REQ) j = j - REQ;
      jj = j[IDX_W-1:0];
      if (!found && mask[jj]) begin
        res   = jj;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [OUT-1:0] popcount(input logic [REQ-1:0] mask);
    logic [OUT-1:0] c;
    c = '0;
    for (int i = 0; i < REQ; i++) c = c + OUT'(mask[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (int'(x) == REQ - 1) ? '0 : x + IDX_W'(1);
  endfunction

  // Pending index 0 is register code 2.
  function automatic logic [OUT-1:0] to_code(input logic [IDX_W-1:0] idx);
    return OUT'(idx) + OUT'(2);
  endfunction

  assign req_act = ~CC_ENCODER_request_InBUS;
  // The presented code identifies the granted pending bit.
  assign cur_idx = IDX_W'(sel_q - OUT'(2));
  assign remain  = mask_q & ~({{(REQ-1){1'b0}}, 1'b1} << cur_idx);

`ifdef CC_ENCODER_ROUNDROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign start_idle  = wrap_inc(ptr_q);
  assign start_serve = wrap_inc(cur_idx);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == SERVE && CC_ENCODER_ready_InLow) ptr_d = cur_idx;
  end

  always_ff @(posedge CC_ENCODER_CLOCK_50 or negedge CC_ENCODER_RESET_InLow) begin
    if (!CC_ENCODER_RESET_InLow) ptr_q <= IDX_W'(REQ - 1);
    else                         ptr_q <= ptr_d;
  end
`else
  assign start_idle  = '0;
  assign start_serve = '0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (|req_act) begin
          mask_d  = req_act;
          cnt_d   = popcount(req_act);
          sel_d   = to_code(pick(req_act, start_idle));
          valid_d = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        // valid is always 1 here, so ready alone completes a handshake.
        if (CC_ENCODER_ready_InLow) begin
          mask_d = remain;
          if (|remain) begin
            sel_d = to_code(pick(remain, start_serve));
            cnt_d = cnt_q - OUT'(1);
          end else begin
            sel_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CC_ENCODER_CLOCK_50 or negedge CC_ENCODER_RESET_InLow) begin
    if (!CC_ENCODER_RESET_InLow) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign CC_ENCODER_selection_OutBUS    = sel_q;
  assign CC_ENCODER_valid_Out           = valid_q;
  assign CC_ENCODER_pendingcount_OutBUS = cnt_q;

endmodule

// File: tb/tb_cc_rr_encoder.sv
// Testbench for cc_rr_encoder: directed batches, expected codes queued
// ahead of time and checked by a monitor on every handshake.
module tb_cc_rr_encoder;

`ifdef CC_ENCODER_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] request;
  logic        ready;
  logic [3:0]  sel;
  logic        valid;
  logic [3:0]  cnt;

  always #5 clk = ~clk;

  cc_rr_encoder dut (
    .CC_ENCODER_CLOCK_50            (clk),
    .CC_ENCODER_RESET_InLow         (rst_n),
    .CC_ENCODER_request_InBUS       (request),
    .CC_ENCODER_ready_InLow         (ready),
    .CC_ENCODER_selection_OutBUS    (sel),
    .CC_ENCODER_valid_Out           (valid),
    .CC_ENCODER_pendingcount_OutBUS (cnt)
  );

  // scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] code, input logic [3:0] count);
    exp_q.push_back({code, count});
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got sel=%0d cnt=%0d, required no transfer", sel, cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({sel, cnt} !== mon_exp) begin
          errors++;
          $display("FAIL mon_code: got sel=%0d cnt=%0d, required sel=%0d cnt=%0d",
                   sel, cnt, mon_exp[7:4], mon_exp[3:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [13:0] m);
    request = ~m;
    tick();
    request = '1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (valid === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 32'(valid), 0);
    check({name, "_sel"},   32'(sel),   0);
    check({name, "_cnt"},   32'(cnt),   0);
  endtask

  initial begin
    rst_n   = 1'b0;
    request = '1;
    ready   = 1'b1;
    repeat (3) tick();
    check("rst_sel",   32'(sel),   0);
    check("rst_valid", 32'(valid), 0);
    check("rst_cnt",   32'(cnt),   0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_allones", 32'(valid), 0);

    // single request, bit 0 -> code 2
    push(4'd2, 4'd1);
    start_batch(14'b00000000000001);
    check("t1_latency", 32'(valid), 1);
    wait_idle("t1_end");

    // bits 0 and 3 back-to-back
    if (RR) begin push(4'd5, 4'd2); push(4'd2, 4'd1); end
    else    begin push(4'd2, 4'd2); push(4'd5, 4'd1); end
    start_batch(14'b00000000001001);
    wait_idle("t2_end");

    // same batch held by ready=0 for 3 cycles
    ready = 1'b0;
    if (RR) begin push(4'd5, 4'd2); push(4'd2, 4'd1); end
    else    begin push(4'd2, 4'd2); push(4'd5, 4'd1); end
    start_batch(14'b00000000001001);
    for (int i = 0; i < 3; i++) begin
      check("hold_sel",   32'(sel),   RR ? 5 : 2);
      check("hold_valid", 32'(valid), 1);
      check("hold_cnt",   32'(cnt),   2);
      tick();
    end
    ready = 1'b1;
    wait_idle("t3_end");

    // reset mid-batch clears everything immediately
    ready = 1'b0;
    start_batch(14'b00000000001001);
    check("prerst_cnt", 32'(cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sel",   32'(sel),   0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_cnt",   32'(cnt),   0);
    ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("postrst_idle", 32'(valid), 0);

    // grant order after a fresh reset: {0,3} then {0,3,5}
    push(4'd2, 4'd2); push(4'd5, 4'd1);
    start_batch(14'b00000000001001);
    wait_idle("t4_end");
    if (RR) begin push(4'd7, 4'd3); push(4'd2, 4'd2); push(4'd5, 4'd1); end
    else    begin push(4'd2, 4'd3); push(4'd5, 4'd2); push(4'd7, 4'd1); end
    start_batch(14'b00000000101001);
    wait_idle("t5_end");

    // bit 6 goes low mid-batch: served only in the following batch
    push(4'd2, 4'd2); push(4'd3, 4'd1); push(4'd8, 4'd1);
    ready   = 1'b0;
    request = ~14'b00000000000011;
    tick();
    request = ~14'b00000001000000;
    tick();
    ready = 1'b1;
    wait_idle("t6_gap");
    tick();
    check("late_valid", 32'(valid), 1);
    check("late_sel",   32'(sel),   8);
    request = '1;
    wait_idle("t6_end");

    repeat (2) tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cc_rr_encoder.md
# cc_rr_encoder

Register-select encoder at the opposite end of the datapath's 4-bit register-select / 14-line active-low decode interface. It collects active-low request lines, one per register code 2..15, and serialises them into 4-bit register-select codes. Each code is delivered with a valid/ready handshake. It sits between the request sources and the select input of the register-file decode path.

## Interface
- DATAWIDTH_ENCODER_REQUEST, 14, number of active-low request lines; line k maps to code k+2.
- DATAWIDTH_ENCODER_OUT, 4, width of the encoded select code.
- CC_ENCODER_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- CC_ENCODER_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_ENCODER_request_InBUS  in  14  active-low request lines; bit k low = request for code k+2.
- CC_ENCODER_ready_InLow  in  1  consumer ready, active-high despite the suffix; a handshake occurs when valid=1 and ready=1 at a rising edge.
- CC_ENCODER_selection_OutBUS  out  4  granted register code, 2..15; 4'b0000 when idle.
- CC_ENCODER_valid_Out  out  1  code is valid.
- CC_ENCODER_pendingcount_OutBUS  out  4  requests remaining in the current batch, including the presented one; range 0..14.

## Operation
- The FSM has two states: IDLE and SERVE. Reset state is IDLE.
- Reset values: selection=0, valid=0, pendingcount=0, pending mask=0, round-robin pointer=13.
- IDLE:
  - If any request bit is low, at the next edge: pending mask <= ~request, count <= popcount(~request), selection <= code of the first pending bit, valid <= 1, state goes to SERVE.
  - Otherwise all outputs stay at their reset values.
- SERVE:
  - selection, valid and pendingcount are held stable while ready=0.
  - On a handshake, clear the granted bit and decrement count.
  - If any bits remain, the next grant is presented at the same edge (back-to-back) and valid stays 1.
  - If no bits remain: valid <= 0, selection <= 0, count <= 0, state goes to IDLE.
- Requests that change during SERVE are ignored. The batch is a snapshot, and new requests are picked up at the next IDLE sample.
- Selection is pending index + 2. Index 0 maps to code 4'b0010 and index 13 maps to code 4'b1111.
- Codes 0 and 1 are never produced.
- All outputs are driven directly from registers; no combinational path runs from an input to an output.

## Timing
- Latency: a request first sampled low at edge N produces valid=1 with its code after edge N.
- Throughput: one code per cycle while ready=1.
- After the last handshake of a batch, valid is low for at least one cycle, which is the IDLE sample cycle.
- A new snapshot is taken in the IDLE cycle following the batch end.
- Asserting reset at any time, including mid-batch with valid=1, immediately clears all state and outputs. No handshake completes on that edge.
- Reset release takes effect at the next rising edge.
- An all-ones request in IDLE causes no state change.

## Configuration
- CC_ENCODER_ROUNDROBIN_EN defined:
  - Grant search starts at (pointer+1) mod 14 and wraps from 13 to 0.
  - On each handshake the pointer is updated to the granted index.
  - The pointer persists across batches.
- CC_ENCODER_ROUNDROBIN_EN undefined:
  - Fixed priority: the lowest pending index is granted first.
  - The pointer register is not implemented.

## Test plan
- Reset, then request=14'b11111111111110 with ready=1 -> one cycle later selection=4'b0010, valid=1, pendingcount=1; one cycle after that valid=0, selection=0.
- Request=14'b11111111110110 (bits 0 and 3 low) with ready=1 -> consecutive codes 2 then 5 with counts 2 then 1, then valid=0.
- Same batch, ready=0 for 3 cycles -> selection=2, valid=1, count=2 held for all 3 cycles; the pair completes after ready rises.
- With ROUNDROBIN_EN: batch with bits 0 and 3, then a batch with bits 0, 3 and 5 -> second batch order is codes 7, 2, 5. Without the macro the order is 2, 5, 7.
- Request bit 6 going low mid-batch -> it is not granted in the current batch and is granted in the next batch.
- Reset asserted while valid=1 and count=2 -> valid, selection and count go to 0 immediately. After release with no requests, the block stays idle.
